// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: status codes, icodes, register IDs and the W-register layout.
package y86_pkg;

  localparam int unsigned DataW   = 64;
  localparam int unsigned NumRegs = 15;

  typedef logic [2:0] stat_t;

  localparam stat_t STAT_AOK = 3'b000;
  localparam stat_t STAT_INS = 3'b001;
  localparam stat_t STAT_ADR = 3'b010;
  localparam stat_t STAT_HLT = 3'b100;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  typedef struct packed {
    logic             valid;
    stat_t            stat;
    logic [3:0]       icode;
    logic [3:0]       dst_e;
    logic [3:0]       dst_m;
    logic [DataW-1:0] val_e;
    logic [DataW-1:0] val_m;
  } w_reg_t;

  // A bubble looks like a NOP that names no destination and never retires.
  localparam w_reg_t W_BUBBLE = '{
    valid: 1'b0,
    stat:  STAT_AOK,
    icode: I_NOP,
    dst_e: RNONE,
    dst_m: RNONE,
    val_e: '0,
    val_m: '0
  };

endpackage

// File: rtl/y86_writeback_stage_if.sv
// Writeback-stage bus: M-stage inputs, pipeline control, decode read ports and W exports.
// master = pipeline side driving the stage, slave = the writeback stage itself.
interface y86_writeback_stage_if;
  import y86_pkg::*;

  logic        W_stall;
  logic        W_bubble;
  stat_t       M_stat;
  logic [3:0]  M_icode;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic [63:0] M_valE;
  logic [63:0] m_valM;
  logic [3:0]  d_srcA;
  logic [3:0]  d_srcB;
  logic [63:0] d_rvalA;
  logic [63:0] d_rvalB;
  stat_t       W_stat;
  logic [3:0]  W_icode;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  stat_t       Stat;
  logic        halted;
  logic [63:0] retired_count;

  modport master (
    output W_stall, W_bubble, M_stat, M_icode, M_dstE, M_dstM, M_valE, m_valM,
    output d_srcA, d_srcB,
    input  d_rvalA, d_rvalB, W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM,
    input  Stat, halted, retired_count
  );

  modport slave (
    input  W_stall, W_bubble, M_stat, M_icode, M_dstE, M_dstM, M_valE, m_valM,
    input  d_srcA, d_srcB,
    output d_rvalA, d_rvalB, W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM,
    output Stat, halted, retired_count
  );

endinterface

// File: rtl/y86_regfile.sv
// 15 x 64 register file: two combinational read ports, two write ports (M beats E on the
// same index). Optional macro WB_BYPASS_EN makes reads return this cycle's write data.
module y86_regfile
  import y86_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [3:0]       raddr_a_i,
  input  logic [3:0]       raddr_b_i,
  output logic [DataW-1:0] rdata_a_o,
  output logic [DataW-1:0] rdata_b_o,
  input  logic             we_e_i,
  input  logic [3:0]       waddr_e_i,
  input  logic [DataW-1:0] wdata_e_i,
  input  logic             we_m_i,
  input  logic [3:0]       waddr_m_i,
  input  logic [DataW-1:0] wdata_m_i
);

  logic [DataW-1:0] rf_q [NumRegs];
  logic [DataW-1:0] rf_d [NumRegs];

  // Next file contents; the M write is applied last so it wins a shared index (popq %rsp).
  always_comb begin
    rf_d = rf_q;
    for (int i = 0; i < NumRegs; i++) begin
      if (we_e_i && (waddr_e_i == 4'(i))) rf_d[i] = wdata_e_i;
      if (we_m_i && (waddr_m_i == 4'(i))) rf_d[i] = wdata_m_i;
    end
  end

  // Register storage with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRegs; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Read ports; RNONE matches no entry and so reads 0. The bypass variant reads the
  // post-commit view, which already carries the M-over-E priority.
  always_comb begin
    rdata_a_o = '0;
    rdata_b_o = '0;
    for (int i = 0; i < NumRegs; i++) begin
`ifdef WB_BYPASS_EN
      if (raddr_a_i == 4'(i)) rdata_a_o = rf_d[i];
      if (raddr_b_i == 4'(i)) rdata_b_o = rf_d[i];
`else
      if (raddr_a_i == 4'(i)) rdata_a_o = rf_q[i];
      if (raddr_b_i == 4'(i)) rdata_b_o = rf_q[i];
`endif
    end
  end

endmodule

// File: rtl/y86_writeback_stage.sv
// Y86-64 writeback stage: W pipeline register, register-file commit, sticky halt, final
// status and retired-instruction counter. Optional macro WB_BYPASS_EN (see y86_regfile).
module y86_writeback_stage
  import y86_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  y86_writeback_stage_if.slave  wb_if
);

  w_reg_t           w_q, w_d, m_in;
  logic             halted_q, halted_d;
  stat_t            stat_q, stat_d;
  logic [DataW-1:0] retired_q, retired_d;
  logic             commit;

  assign m_in = '{
    valid: 1'b1,
    stat:  wb_if.M_stat,
    icode: wb_if.M_icode,
    dst_e: wb_if.M_dstE,
    dst_m: wb_if.M_dstM,
    val_e: wb_if.M_valE,
    val_m: wb_if.m_valM
  };

  // The current W contents are written back at the coming edge only if healthy and running.
  always_comb commit = !halted_q && (w_q.stat == STAT_AOK);

  // Next W register, halt latch and retire count.
  always_comb begin
    w_d       = w_q;
    halted_d  = halted_q;
    stat_d    = stat_q;
    retired_d = retired_q;
    if (!halted_q) begin
      if (!wb_if.W_stall) begin
        w_d = wb_if.W_bubble ? W_BUBBLE : m_in;
      end
      if (w_q.valid && (w_q.stat != STAT_AOK)) begin
        halted_d = 1'b1;
        stat_d   = w_q.stat;
      end
    end
    if (commit && w_q.valid) begin
      retired_d = retired_q + 64'd1;
    end
  end

  // State registers, asynchronously cleared to a bubble / running / zero count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q       <= W_BUBBLE;
      halted_q  <= 1'b0;
      stat_q    <= STAT_AOK;
      retired_q <= '0;
    end else begin
      w_q       <= w_d;
      halted_q  <= halted_d;
      stat_q    <= stat_d;
      retired_q <= retired_d;
    end
  end

  y86_regfile u_regfile (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .raddr_a_i (wb_if.d_srcA),
    .raddr_b_i (wb_if.d_srcB),
    .rdata_a_o (wb_if.d_rvalA),
    .rdata_b_o (wb_if.d_rvalB),
    .we_e_i    (commit),
    .waddr_e_i (w_q.dst_e),
    .wdata_e_i (w_q.val_e),
    .we_m_i    (commit),
    .waddr_m_i (w_q.dst_m),
    .wdata_m_i (w_q.val_m)
  );

  // W exports for forwarding; after a halt Stat reports the latched fault status.
  assign wb_if.W_stat        = w_q.stat;
  assign wb_if.W_icode       = w_q.icode;
  assign wb_if.W_dstE        = w_q.dst_e;
  assign wb_if.W_dstM        = w_q.dst_m;
  assign wb_if.W_valE        = w_q.val_e;
  assign wb_if.W_valM        = w_q.val_m;
  assign wb_if.Stat          = halted_q ? stat_q : w_q.stat;
  assign wb_if.halted        = halted_q;
  assign wb_if.retired_count = retired_q;

endmodule
